// File: rtl/bcd2bin_seq_if.sv
// rtl/bcd2bin_seq_if.sv - start/busy/done handshake bundle for the BCD to binary converter
interface bcd2bin_seq_if #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
);
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic [BW-1:0]         binout;

  modport master (
    output start, bcd_in,
    input  busy, done, err, binout
  );

  modport slave (
    input  start, bcd_in,
    output busy, done, err, binout
  );
endinterface

// File: rtl/bcd2bin_seq.sv
// rtl/bcd2bin_seq.sv - sequential packed-BCD to binary converter (reverse double-dabble)
module bcd2bin_seq #(
  parameter int DIGITS = 4,
  parameter int BW     = 14
) (
  input  logic             clk,
  input  logic             rst,
  bcd2bin_seq_if.slave     bus
);

  typedef enum logic {
    IDLE = 1'b0,
    CONV = 1'b1
  } state_t;

  localparam int             BCDW      = 4 * DIGITS;
  localparam logic [BW-1:0]  LAST_STEP = BW[BW-1:0] - {{(BW-1){1'b0}}, 1'b1};
  localparam logic [BW-1:0]  ONE       = {{(BW-1){1'b0}}, 1'b1};

  state_t            state, state_n;
  logic [BW-1:0]     cnt, cnt_n;
  logic [BCDW-1:0]   bcd, bcd_n;
  logic [BW-1:0]     bin, bin_n;
  logic              busy_q, busy_n;
  logic              done_q, done_n;
  logic              err_q, err_n;
  logic [BW-1:0]     binout_q, binout_n;

  logic [BCDW-1:0]   bcd_sh;
  logic [BCDW-1:0]   bcd_corr;
  logic [BW-1:0]     bin_sh;
  logic              bad_digit;

  // One reverse double-dabble step: shift right, then pull every digit >= 8 down by 3
  always_comb begin
    bcd_sh   = {1'b0, bcd[BCDW-1:1]};
    bin_sh   = {bcd[0], bin[BW-1:1]};
    bcd_corr = bcd_sh;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_sh[4*i +: 4] >= 4'd8) begin
        bcd_corr[4*i +: 4] = bcd_sh[4*i +: 4] - 4'd3;
      end
    end
  end

  // Flag an operand that holds any non-decimal digit
  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) begin
        bad_digit = 1'b1;
      end
    end
  end

  // Next-state and output decode; done is a pulse, result/err hold between pulses
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    bcd_n    = bcd;
    bin_n    = bin;
    busy_n   = busy_q;
    done_n   = 1'b0;
    err_n    = err_q;
    binout_n = binout_q;
    unique case (state)
      IDLE: begin
        busy_n = 1'b0;
        if (bus.start) begin
          if (bad_digit) begin
            done_n   = 1'b1;
            err_n    = 1'b1;
            binout_n = '0;
          end else begin
            bcd_n   = bus.bcd_in;
            bin_n   = '0;
            cnt_n   = '0;
            busy_n  = 1'b1;
            state_n = CONV;
          end
        end
      end
      CONV: begin
        bcd_n = bcd_corr;
        bin_n = bin_sh;
        cnt_n = cnt + ONE;
        if (cnt == LAST_STEP) begin
          binout_n = bin_sh;
          done_n   = 1'b1;
          err_n    = 1'b0;
          busy_n   = 1'b0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State and output registers; reset aborts any conversion in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      bcd      <= '0;
      bin      <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      binout_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      bcd      <= bcd_n;
      bin      <= bin_n;
      busy_q   <= busy_n;
      done_q   <= done_n;
      err_q    <= err_n;
      binout_q <= binout_n;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.binout = binout_q;

endmodule

// File: tb/tb_bcd2bin_seq.sv
// tb/tb_bcd2bin_seq.sv - directed-vector bench for bcd2bin_seq
module tb_bcd2bin_seq;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  bcd2bin_seq_if #(.DIGITS(4), .BW(14)) bus ();

  bcd2bin_seq #(.DIGITS(4), .BW(14)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle 1ns past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a conversion and watch 20 cycles: first done index, busy count, done count
  task automatic run_conv(input logic [15:0] val, output int lat, output int busy_cyc,
                          output int done_cnt, output logic [13:0] res, output logic e);
    lat = -1; busy_cyc = 0; done_cnt = 0; res = '0; e = 1'b0;
    bus.start  = 1'b1;
    bus.bcd_in = val;
    tick();
    bus.start  = 1'b0;
    bus.bcd_in = 16'hxxxx;
    for (int k = 0; k < 20; k++) begin
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        done_cnt++;
        if (lat < 0) begin
          lat = k;
          res = bus.binout;
          e   = bus.err;
        end
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.bcd_in = '0;
    tick(); tick();
    rst = 1'b0;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", bus.err); end
    vectors++; if (bus.binout !== 14'h0) begin miscompares++; $display("FAIL reset_binout got %h want 0", bus.binout); end
  endtask

  task automatic test_zero();
    int lat, bc, dc; logic [13:0] r; logic e;
    run_conv(16'h0000, lat, bc, dc, r, e);
    vectors++; if (lat !== 14) begin miscompares++; $display("FAIL zero_latency got %0d want 14", lat); end
    vectors++; if (bc !== 14) begin miscompares++; $display("FAIL zero_busy_cycles got %0d want 14", bc); end
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL zero_done_count got %0d want 1", dc); end
    vectors++; if (r !== 14'h0) begin miscompares++; $display("FAIL zero_binout got %h want 0", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL zero_err got %b want 0", e); end
  endtask

  task automatic test_values();
    logic [15:0] ins [3] = '{16'h9999, 16'h1234, 16'h0100};
    logic [13:0] exp [3] = '{14'h270F, 14'h04D2, 14'h0064};
    int lat, bc, dc; logic [13:0] r; logic e;
    for (int i = 0; i < 3; i++) begin
      run_conv(ins[i], lat, bc, dc, r, e);
      vectors++; if (r !== exp[i]) begin miscompares++; $display("FAIL value_binout in=%h got %h want %h", ins[i], r, exp[i]); end
      vectors++; if (dc !== 1) begin miscompares++; $display("FAIL value_done_count in=%h got %0d want 1", ins[i], dc); end
      vectors++; if (lat !== 14) begin miscompares++; $display("FAIL value_latency in=%h got %0d want 14", ins[i], lat); end
    end
  endtask

  task automatic test_invalid();
    int lat, bc, dc; logic [13:0] r; logic e;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h12A4;
    tick();
    bus.start  = 1'b0;
    vectors++; if (bus.done !== 1'b1) begin miscompares++; $display("FAIL invalid_done got %b want 1", bus.done); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL invalid_err got %b want 1", bus.err); end
    vectors++; if (bus.binout !== 14'h0) begin miscompares++; $display("FAIL invalid_binout got %h want 0", bus.binout); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL invalid_busy got %b want 0", bus.busy); end
    tick();
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL invalid_done_pulse got %b want 0", bus.done); end
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL invalid_busy_after got %b want 0", bus.busy); end
    vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL invalid_err_held got %b want 1", bus.err); end
    run_conv(16'h0042, lat, bc, dc, r, e);
    vectors++; if (r !== 14'h002A) begin miscompares++; $display("FAIL after_invalid_binout got %h want 002a", r); end
    vectors++; if (e !== 1'b0) begin miscompares++; $display("FAIL after_invalid_err got %b want 0", e); end
  endtask

  task automatic test_ignore_busy();
    int dc = 0; logic [13:0] r = '0;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0500;
    tick();
    for (int c = 1; c < 25; c++) begin
      bus.start  = (c == 3 || c == 10);
      bus.bcd_in = (c == 3 || c == 10) ? 16'h0999 : 16'h0000;
      if (bus.done) begin dc++; r = bus.binout; end
      tick();
    end
    bus.start = 1'b0;
    vectors++; if (dc !== 1) begin miscompares++; $display("FAIL ignore_done_count got %0d want 1", dc); end
    vectors++; if (r !== 14'h01F4) begin miscompares++; $display("FAIL ignore_binout got %h want 01f4", r); end
  endtask

  task automatic test_reset_abort();
    int dc = 0, lat, bc, dc2; logic [13:0] r; logic e;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0777;
    tick();
    bus.start  = 1'b0;
    for (int c = 1; c < 6; c++) tick();
    rst = 1'b1;
    tick();
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy got %b want 0", bus.busy); end
    vectors++; if (bus.done !== 1'b0) begin miscompares++; $display("FAIL abort_done got %b want 0", bus.done); end
    vectors++; if (bus.err !== 1'b0) begin miscompares++; $display("FAIL abort_err got %b want 0", bus.err); end
    vectors++; if (bus.binout !== 14'h0) begin miscompares++; $display("FAIL abort_binout got %h want 0", bus.binout); end
    rst = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (bus.done) dc++;
      tick();
    end
    vectors++; if (dc !== 0) begin miscompares++; $display("FAIL abort_stray_done got %0d want 0", dc); end
    run_conv(16'h0001, lat, bc, dc2, r, e);
    vectors++; if (r !== 14'h0001) begin miscompares++; $display("FAIL abort_restart_binout got %h want 0001", r); end
    vectors++; if (lat !== 14) begin miscompares++; $display("FAIL abort_restart_latency got %0d want 14", lat); end
  endtask

  task automatic test_back_to_back();
    int t1 = -1, t2 = -1; logic [13:0] r1 = '0, r2 = '0;
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0010;
    tick();
    bus.bcd_in = 16'h0020;
    for (int k = 0; k < 40; k++) begin
      if (bus.done) begin
        if (t1 < 0) begin t1 = k; r1 = bus.binout; end
        else if (t2 < 0) begin t2 = k; r2 = bus.binout; end
      end
      tick();
      if (t1 >= 0) bus.start = 1'b0;
    end
    bus.start = 1'b0;
    vectors++; if (r1 !== 14'h000A) begin miscompares++; $display("FAIL b2b_first_binout got %h want 000a", r1); end
    vectors++; if (t1 < 0 || t2 - t1 !== 15) begin miscompares++; $display("FAIL b2b_spacing got %0d want 15", t2 - t1); end
    vectors++; if (r2 !== 14'h0014) begin miscompares++; $display("FAIL b2b_second_binout got %h want 0014", r2); end
  endtask

  initial begin
    bus.start  = 1'b0;
    bus.bcd_in = '0;
    test_reset();
    test_zero();
    test_values();
    test_invalid();
    test_ignore_busy();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bcd2bin_seq.md
# bcd2bin_seq

Sequential packed-BCD to binary converter for the decimal-mode datapath. It is the counterpart to the BCD adjust logic: the adjust logic produces packed BCD results, and this block turns packed BCD operands back into plain binary. It uses a reverse double-dabble algorithm (shift right, then subtract 3 from every digit ≥ 8), performing one iteration per clock under a start/busy/done handshake. It serves the decimal-display and decimal-operand paths around the core.

## Interface
- DIGITS, 4: number of packed BCD digits on `bcd_in`.
- BW, 14: binary result width; must satisfy 2^BW > 10^DIGITS − 1 (14 for 4 digits).
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a conversion; sampled only while `busy`=0.
- bcd_in  in  4*DIGITS  packed BCD operand, digit 0 in bits [3:0]; sampled with `start`.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse; `binout`/`err` valid from this cycle on.
- err  out  1  operand had a digit > 9; valid when `done`=1, held until the next `done`.
- binout  out  BW  binary result; held until the next `done`.

## Operation
- States: IDLE and CONV. A BW-wide step counter and a work register {bcd[4*DIGITS-1:0], bin[BW-1:0]} are kept internally.
- **IDLE, start=1, all digits ≤ 9:**
  - Load bcd ← `bcd_in` and bin ← 0.
  - Clear the counter, set `busy`=1 and go to CONV.
- **IDLE, start=1, any digit > 9:**
  - No conversion is performed and the state stays IDLE.
  - On the same edge set `done`=1, `err`=1, `binout`=0.
- **CONV, each edge:**
  - Shift {bcd, bin} right by one; the bcd LSB enters the bin MSB.
  - Then, on every shifted digit ≥ 8, subtract 3. Each digit is corrected independently with 4-bit arithmetic and no inter-digit borrow.
  - Increment the counter.
- **CONV, counter = BW−1 (last step):**
  - On this edge, write the post-step bin to `binout`.
  - Set `done`=1, `err`=0, `busy`=0 and return to IDLE.
- `done` is deasserted on every edge on which it is not being set.
- `start` while `busy`=1 is ignored; there is no queueing.
- `bcd_in` is don't-care outside the sampling edge.
- After BW steps the bcd field is 0 for any valid operand. This is an internal invariant only; it drives no output.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `binout`=0, state IDLE, counter 0.
- Reset asserted mid-conversion:
  - Aborts the conversion at that edge; no `done` is produced and all outputs take their reset values.
  - Reset has priority over `start`.
- **Valid operand, `start` sampled at edge E0:**
  - `busy`=1 from E0 to E_BW.
  - Steps occur on edges E1..E_BW.
  - `done`=1 for exactly the cycle after E_BW. Latency from the sampling edge to `done` is BW clocks (14 by default).
- **Invalid operand, `start` sampled at E0:** `done`=`err`=1 for the cycle after E0, and `busy` stays 0.
- **Back-to-back:**
  - `start` high during the `done` cycle (where `busy`=0) is accepted.
  - Sustained throughput is one conversion every BW+1 clocks.
- `binout` and `err` change only on edges that set `done`.

## Test plan
- Reset, then `start` with `bcd_in`=0x0000 → `busy` high for 14 cycles, `done` pulse 14 clocks after the start edge, `binout`=0, `err`=0.
- `bcd_in`=0x9999 → `binout`=0x270F; `bcd_in`=0x1234 → `binout`=0x04D2; `bcd_in`=0x0100 → `binout`=0x0064. Each `done` lasts one cycle.
- `bcd_in`=0x12A4 → `done`=`err`=1 one clock after the start edge, `binout`=0, `busy` never asserted. A following valid 0x0042 → `binout`=0x002A, `err`=0.
- Start 0x0500, pulse `start` with 0x0999 at cycles 3 and 10 → the second start is ignored: exactly one `done`, with `binout`=0x01F4.
- Start 0x0777, assert `rst` at cycle 6 → no `done`, all outputs 0. Start 0x0001 after release → `binout`=1.
- Start 0x0010, then hold `start`=1 with 0x0020 through the `done` cycle → second `done` exactly 15 clocks after the first, `binout`=0x0014.
